// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: streams message bytes into big-endian 512-bit blocks with SHA-256 padding and length field
module sha256_msg_padder #(
  parameter int LEN_W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         block_valid,
  output logic [511:0] block_data,
  output logic         block_first,
  output logic         block_last,
  input  logic         block_ready,
  output logic         len_error
);
  typedef enum logic [1:0] {FILL, OUT, PAD2} state_t;
  typedef enum logic [1:0] {NONE, LENBLK, PADBLK} pend_t;
  state_t state_q, state_d;
  pend_t pend_q, pend_d;
  logic [511:0] buf_q, buf_d;
  logic [5:0] pos_q, pos_d, pos_n;
  logic [LEN_W-1:0] len_q, len_d, len_n;
  logic first_q, first_d, last_q, last_d, err_q, err_d;
  assign in_ready    = state_q == FILL;
  assign block_valid = state_q == OUT;
  assign block_data  = buf_q;
  assign block_first = first_q;
  assign block_last  = last_q;
  assign len_error   = err_q;
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    buf_d   = buf_q;
    pos_d   = pos_q;
    len_d   = len_q;
    first_d = first_q;
    last_d  = last_q;
    err_d   = err_q;
    pos_n   = pos_q + 6'd1;
    len_n   = len_q + LEN_W'(1);
    case (state_q)
      FILL: if (in_valid) begin
        // byte i of the block lives at bits [(63-i)*8 +: 8], and 63-i is ~i for a 6-bit index
        buf_d[{~pos_q, 3'b0} +: 8] = in_data;
        pos_d = pos_n;
        len_d = len_n;
        err_d = err_q | (&len_q);
        if (in_last) begin
          state_d = OUT;
          if (pos_n != 6'd0) begin
            buf_d[{~pos_n, 3'b0} +: 8] = 8'h80;
            if (pos_n <= 6'd55) begin
              buf_d[63:0] = 64'(len_n) << 3;
              last_d = 1'b1;
            end else pend_d = LENBLK;
          end else pend_d = PADBLK;
        end else if (pos_n == 6'd0) state_d = OUT;
      end
      OUT: if (block_ready) begin
        buf_d   = '0;
        first_d = last_q;
        last_d  = 1'b0;
        if (pend_q == NONE) begin
          state_d = FILL;
          if (last_q) begin
            len_d = '0;
            pos_d = '0;
            err_d = 1'b0;
          end
        end else state_d = PAD2;
      end
      PAD2: begin
        buf_d[511:504] = pend_q == PADBLK ? 8'h80 : 8'h00;
        buf_d[63:0]    = 64'(len_q) << 3;
        last_d  = 1'b1;
        pend_d  = NONE;
        state_d = OUT;
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FILL;
      pend_q  <= NONE;
      buf_q   <= '0;
      pos_q   <= '0;
      len_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      pos_q   <= pos_d;
      len_q   <= len_d;
      first_q <= first_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: random and directed messages checked against a byte-queue padding model
module tb_sha256_msg_padder;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, in_valid, in_last, in_ready, block_valid, block_first, block_last, block_ready, len_error;
  logic [7:0] in_data;
  logic [511:0] block_data;
  logic in_valid6, in_last6, in_ready6, block_valid6, block_first6, block_last6, block_ready6, len_error6;
  logic [7:0] in_data6;
  logic [511:0] block_data6;
  int n_vec = 0, n_err = 0;
  logic [7:0] msg_q[$];
  logic [511:0] exp_d[$];
  logic exp_f[$], exp_l[$];

  sha256_msg_padder dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .block_valid(block_valid), .block_data(block_data), .block_first(block_first),
    .block_last(block_last), .block_ready(block_ready), .len_error(len_error)
  );
  sha256_msg_padder #(.LEN_W(6)) dut6 (
    .clock(clock), .reset(reset), .in_valid(in_valid6), .in_data(in_data6), .in_last(in_last6),
    .in_ready(in_ready6), .block_valid(block_valid6), .block_data(block_data6), .block_first(block_first6),
    .block_last(block_last6), .block_ready(block_ready6), .len_error(len_error6)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp();
    logic [7:0] pad[$];
    logic [63:0] bits;
    logic [511:0] blk;
    int nb;
    pad = msg_q;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bits = 64'(msg_q.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) pad.push_back(bits[8*k +: 8]);
    nb = pad.size() / 64;
    exp_d = {};
    exp_f = {};
    exp_l = {};
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk = {blk[503:0], pad[64*b+i]};
      exp_d.push_back(blk);
      exp_f.push_back(b == 0);
      exp_l.push_back(b == nb - 1);
    end
  endtask

  task automatic reset_checks();
    check("rst_in_ready", in_ready, 1);
    check("rst_block_valid", block_valid, 0);
    check("rst_block_data", block_data, 0);
    check("rst_block_first", block_first, 1);
    check("rst_block_last", block_last, 0);
    check("rst_len_error", len_error, 0);
  endtask

  task automatic run_msg(input int bp, input int hold, input bit junk);
    int idx, got, cyc, held;
    bit prev_v, prev_hs, prev_last, chk_next;
    logic [511:0] prev_d;
    idx = 0; got = 0; cyc = 0; held = 0;
    prev_v = 0; prev_hs = 0; prev_last = 0; chk_next = 0; prev_d = '0;
    build_exp();
    while (got < exp_d.size() && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      if (chk_next) check("latency", block_valid, 1);
      chk_next = 0;
      if (prev_hs) begin
        check("gap", block_valid, 0);
        if (prev_last) check("ready_after", in_ready, 1);
      end else if (prev_v) check("stable", block_data, prev_d);
      if (block_valid) check("in_ready_out", in_ready, 0);
      in_valid = idx < msg_q.size() || junk;
      in_data  = idx < msg_q.size() ? msg_q[idx] : 8'($urandom);
      in_last  = idx < msg_q.size() ? (idx == msg_q.size() - 1) : 1'($urandom);
      if (block_valid && held < hold) begin
        block_ready = 1'b0;
        held++;
      end else block_ready = $urandom_range(99) >= bp;
      prev_hs = block_valid && block_ready;
      prev_v = block_valid;
      prev_d = block_data;
      prev_last = block_last;
      if (in_valid && in_ready && idx < msg_q.size()) begin
        chk_next = idx == msg_q.size() - 1;
        idx++;
      end
      if (prev_hs) begin
        check("block_data", block_data, exp_d[got]);
        check("block_first", block_first, exp_f[got]);
        check("block_last", block_last, exp_l[got]);
        got++;
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    block_ready = 1'b0;
    check("blocks_done", got, exp_d.size());
    if (prev_hs) begin
      check("gap", block_valid, 0);
      check("ready_after", in_ready, 1);
    end
    if (hold > 0) check("hold_cycles", held, hold);
  endtask

  initial begin
    logic [511:0] blk6;
    reset = 1'b1; in_valid = 0; in_data = 0; in_last = 0; block_ready = 0;
    in_valid6 = 0; in_data6 = 0; in_last6 = 0; block_ready6 = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    reset_checks();
    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg(0, 0, 0);
    msg_q = {};
    repeat (55) msg_q.push_back(8'h00);
    run_msg(0, 0, 0);
    msg_q = {};
    repeat (56) msg_q.push_back(8'hFF);
    run_msg(0, 0, 0);
    msg_q = {};
    repeat (64) msg_q.push_back(8'($urandom));
    run_msg(0, 0, 0);
    msg_q = {8'h61};
    run_msg(0, 0, 0);
    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg(0, 7, 1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0;
    end
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    reset_checks();
    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg(0, 0, 0);
    repeat (6) begin
      msg_q = {};
      repeat ($urandom_range(150, 1)) msg_q.push_back(8'($urandom));
      run_msg(30, 0, 1);
    end
    blk6 = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (i > 0) check("len6_err_early", len_error6, 0);
      in_valid6 = 1'b1; in_data6 = 8'(i); in_last6 = i == 63;
      blk6 = {blk6[503:0], 8'(i)};
    end
    @(negedge clock);
    in_valid6 = 1'b0;
    check("len6_err_set", len_error6, 1);
    check("len6_blk1_valid", block_valid6, 1);
    check("len6_blk1_data", block_data6, blk6);
    check("len6_blk1_last", block_last6, 0);
    block_ready6 = 1'b1;
    @(negedge clock);
    check("len6_gap", block_valid6, 0);
    @(negedge clock);
    check("len6_blk2_valid", block_valid6, 1);
    check("len6_blk2_data", block_data6, {8'h80, 504'b0});
    check("len6_blk2_last", block_last6, 1);
    check("len6_err_held", len_error6, 1);
    @(negedge clock);
    block_ready6 = 1'b0;
    check("len6_err_clear", len_error6, 0);
    check("len6_first", block_first6, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
